// File: rtl/fix_div.sv
// Sequential sign-magnitude restoring divider: one quotient bit per clock,
// valid/ready on both sides, saturated quotient and div_by_zero flag on a zero divisor.
module fix_div #(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [N:0] dividend,
  input  logic [N:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [N:0] quotient,
  output logic [N:0] remainder,
  output logic       div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          q_sign_q, q_sign_d;
  logic          r_sign_q, r_sign_d;
  logic          zero_q, zero_d;
  logic          out_valid_q, out_valid_d;
  logic [N:0]    quotient_q, quotient_d;
  logic [N:0]    remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    rem_shift;
  logic [N:0]    rem_sub;
  logic          qbit;
  logic [N-1:0]  rem_next;
  logic [N-1:0]  quo_next;

  // Attach a sign to a magnitude, never producing negative zero.
  function automatic logic [N:0] sm_pack(input logic sign, input logic [N-1:0] mag);
    sm_pack = {sign & (|mag), mag};
  endfunction

  always_comb begin
    rem_shift = {rem_q, dvd_q[N-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    // A borrow out of the trial subtraction means partial remainder < divisor.
    qbit      = ~rem_sub[N];
    rem_next  = qbit ? rem_sub[N-1:0] : rem_shift[N-1:0];
    quo_next  = {quo_q[N-2:0], qbit};

    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    q_sign_d    = q_sign_q;
    r_sign_d    = r_sign_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d    = dividend[N-1:0];
          dvs_d    = divisor[N-1:0];
          q_sign_d = dividend[N] ^ divisor[N];
          r_sign_d = dividend[N];
          zero_d   = (divisor[N-1:0] == '0);
          count_d  = '0;
          rem_d    = '0;
          quo_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // A zero divisor spends a single cycle here so its result appears one cycle after acceptance.
        if (zero_q) begin
          quotient_d  = sm_pack(q_sign_q, '1);
          remainder_d = sm_pack(r_sign_q, dvd_q);
          dbz_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          rem_d   = rem_next;
          dvd_d   = {dvd_q[N-2:0], 1'b0};
          quo_d   = quo_next;
          count_d = count_q + 1'b1;
          if (count_q == CW'(N - 1)) begin
            quotient_d  = sm_pack(q_sign_q, quo_next);
            remainder_d = sm_pack(r_sign_q, rem_next);
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          dbz_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      q_sign_q    <= 1'b0;
      r_sign_q    <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      q_sign_q    <= q_sign_d;
      r_sign_q    <= r_sign_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fix_div.sv
// Randomized bench for fix_div: a cycle-level reference (plain integer division plus
// a latency countdown) is compared against the DUT on every falling clock edge.
module tb_fix_div;
  localparam int N = 32;

  typedef struct packed {
    logic       z;
    logic [N:0] q;
    logic [N:0] r;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [N:0] dividend = '0;
  logic [N:0] divisor = '0;
  logic       in_ready;
  logic       out_valid;
  logic [N:0] quotient;
  logic [N:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail = 0;

  fix_div #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference result from ordinary unsigned division of the magnitudes.
  function automatic res_t ref_div(input logic [N:0] a, input logic [N:0] b);
    longint unsigned am, bm, qm, rm;
    res_t res;
    am = 64'(a[N-1:0]);
    bm = 64'(b[N-1:0]);
    if (bm == 0) begin
      res.z = 1'b1;
      qm = (64'd1 << N) - 1;
      rm = am;
    end else begin
      res.z = 1'b0;
      qm = am / bm;
      rm = am % bm;
    end
    res.q = {(a[N] ^ b[N]) && (qm != 0), qm[N-1:0]};
    res.r = {a[N] && (rm != 0), rm[N-1:0]};
    return res;
  endfunction

  // Model state: 0 idle, 1 busy (counting down to the result), 2 result presented.
  int   m_st = 0;
  int   m_cd = 0;
  res_t m_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_st = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      chk("in_ready", in_ready, m_st == 0);
      chk("out_valid", out_valid, m_st == 2);
      if (m_st == 2) begin
        chk("quotient", quotient, m_exp.q);
        chk("remainder", remainder, m_exp.r);
        chk("div_by_zero", div_by_zero, m_exp.z);
      end
      case (m_st)
        0: if (in_valid) begin
          m_exp = ref_div(dividend, divisor);
          m_cd  = m_exp.z ? 1 : N;
          m_st  = 1;
        end
        1: begin
          m_cd--;
          if (m_cd == 0) m_st = 2;
        end
        default: if (out_ready) m_st = 0;
      endcase
    end
  end

  task automatic do_div(input logic [N:0] a, input logic [N:0] b, input int hold,
                        input bit toggle, output res_t got, output int lat);
    int w;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = {1'($urandom_range(0, 1)), 32'($urandom)};
        divisor  = {1'($urandom_range(0, 1)), 32'($urandom)};
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) chk("result_timeout", 0, 1);
    got = {div_by_zero, quotient, remainder};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {div_by_zero, quotient, remainder}, got);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_valid", out_valid, 0);
    chk("consume_in_ready", in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t got;
    int   lat;
    logic [N:0] a, b;
    logic [N-1:0] am, bm;

    // Pin the reference model against hand-computed values.
    chk("model_100_m7", ref_div(33'h0_0000_0064, 33'h1_0000_0007),
        {1'b0, 33'h1_0000_000E, 33'h0_0000_0002});
    chk("model_dbz", ref_div(33'h1_0000_1234, 33'h1_0000_0000),
        {1'b1, 33'h0_FFFF_FFFF, 33'h1_0000_1234});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_div(33'h0_0000_0064, 33'h1_0000_0007, 0, 1'b0, got, lat);
    chk("basic_lat", lat, 32);
    chk("basic_res", got, {1'b0, 33'h1_0000_000E, 33'h0_0000_0002});

    do_div(33'h1_0000_0003, 33'h0_0000_0005, 0, 1'b0, got, lat);
    chk("negzero_res", got, {1'b0, 33'h0_0000_0000, 33'h1_0000_0003});

    do_div(33'h0_FFFF_FFFF, 33'h1_0000_0001, 0, 1'b0, got, lat);
    chk("ext_max_res", got, {1'b0, 33'h1_FFFF_FFFF, 33'h0_0000_0000});

    do_div(33'h0_0000_0005, 33'h0_FFFF_FFFF, 0, 1'b0, got, lat);
    chk("ext_small_res", got, {1'b0, 33'h0_0000_0000, 33'h0_0000_0005});

    do_div(33'h1_0000_1234, 33'h1_0000_0000, 0, 1'b0, got, lat);
    chk("dbz_lat", lat, 1);
    chk("dbz_res", got, {1'b1, 33'h0_FFFF_FFFF, 33'h1_0000_1234});

    // 1000 / -3 with backpressure and junk inputs during the calculation.
    do_div(33'h0_0000_03E8, 33'h1_0000_0003, 10, 1'b1, got, lat);
    chk("bp_lat", lat, 32);
    chk("bp_res", got, {1'b0, 33'h1_0000_014D, 33'h0_0000_0001});

    // Reset 16 cycles into a divide; the partial result must never appear.
    @(posedge clk); #1;
    dividend = 33'h0_0012_3456;
    divisor  = 33'h0_0000_0033;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_div(33'h0_0000_0064, 33'h0_0000_0007, 0, 1'b0, got, lat);
    chk("after_rst_res", got, {1'b0, 33'h0_0000_000E, 33'h0_0000_0002});

    for (int t = 0; t < 40; t++) begin
      am = 32'($urandom);
      if ($urandom_range(0, 3) == 0) am = 32'($urandom_range(0, 20));
      case ($urandom_range(0, 3))
        0: bm = 32'($urandom_range(0, 15));
        1: bm = 32'($urandom);
        2: bm = am >> $urandom_range(0, 31);
        default: bm = 32'($urandom_range(1, 1000));
      endcase
      a = {1'($urandom_range(0, 1)), am};
      b = {1'($urandom_range(0, 1)), bm};
      do_div(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), got, lat);
      chk("rand_lat", lat, (bm == 0) ? 1 : N);
      chk("rand_res", got, ref_div(a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
